seven_segment_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits, hex per nibble.

---
 rtl/seven_seg_pkg.sv | 19 +
 rtl/hex_to_seg_decode.sv | 14 +
 rtl/seven_segment_scan_driver.sv | 138 +++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-high {A,B,C,D,E,F,G} with A as the MSB.
package seven_seg_pkg;

   typedef enum logic {
      SCAN_BLANK,
      SCAN_ACTIVE
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [6:0] SEG_HEX_LUT [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,
      7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F,
      7'h4E, 7'h3D, 7'h4F, 7'h47
   };

endpackage

// File: rtl/hex_to_seg_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup; every nibble value has an entry.
   always_comb begin
      seg = SEG_HEX_LUT[nibble];
   end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed hex display driver: latches a packed value and scans one
// digit per slot, each slot being a blank guard interval followed by a lit phase.
// All outputs are registered, so they trail the scan state by one clock.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seven_segment_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned CLKS_PER_DIGIT = 1000,
   parameter int unsigned BLANK_CLKS     = 16,
   parameter int unsigned SEG_ACTIVE_LOW = 0,
   parameter int unsigned DIG_ACTIVE_LOW = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic                      load_i,
   input  logic                      display_en_i,
   output logic [6:0]                seg_o,
   output logic [NUM_DIGITS-1:0]     dig_en_o,
   output logic                      frame_o
);

   localparam int unsigned CNT_BIG  = (CLKS_PER_DIGIT > BLANK_CLKS) ? CLKS_PER_DIGIT : BLANK_CLKS;
   localparam int unsigned CNT_SPAN = (CNT_BIG > 2) ? CNT_BIG : 2;
   localparam int unsigned CW       = $clog2(CNT_SPAN);
   localparam int unsigned IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] ACT_LAST = CW'(CLKS_PER_DIGIT - 1);
   localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CLKS > 0) ? BLANK_CLKS - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   // With no guard interval every slot starts directly in the lit phase.
   localparam scan_state_t SLOT_START = (BLANK_CLKS == 0) ? SCAN_ACTIVE : SCAN_BLANK;

   localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [4*NUM_DIGITS-1:0] value_r;
   logic [IW-1:0]           idx;
   logic [CW-1:0]           cnt;
   scan_state_t             state;

   logic [3:0]              nibble;
   logic [6:0]              decoded;
   logic                    show;
   logic                    slot_done;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   dig_next;

   hex_to_seg_decode u_decode (
      .nibble (nibble),
      .seg    (decoded)
   );

   // Display value register; only load_i or reset changes it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         value_r <= '0;
      end else if (load_i) begin
         value_r <= value_i;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit is shown unless it and every higher nibble are zero; digit 0 always shown.
   always_comb begin
      show = (idx == '0);
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if ((k >= 32'(idx)) && (value_r[4*k +: 4] != 4'h0)) begin
            show = 1'b1;
         end
      end
   end
`else
   // Every digit decodes its own nibble, leading zeros included.
   always_comb begin
      show = 1'b1;
   end
`endif

   // Next-cycle output patterns, already in board polarity.
   always_comb begin
      nibble    = value_r[4*idx +: 4];
      slot_done = (state == SCAN_ACTIVE) && (cnt == ACT_LAST);
      seg_next  = show ? decoded : SEG_OFF;
      if (SEG_ACTIVE_LOW != 0) begin
         seg_next = ~seg_next;
      end
      dig_next = '0;
      if ((state == SCAN_ACTIVE) && display_en_i) begin
         dig_next = NUM_DIGITS'(1) << idx;
      end
      if (DIG_ACTIVE_LOW != 0) begin
         dig_next = ~dig_next;
      end
   end

   // Scan FSM, slot counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= SLOT_START;
         idx      <= '0;
         cnt      <= '0;
         seg_o    <= SEG_IDLE;
         dig_en_o <= DIG_IDLE;
         frame_o  <= 1'b0;
      end else begin
         seg_o    <= seg_next;
         dig_en_o <= dig_next;
         frame_o  <= slot_done && (idx == IDX_LAST);
         case (state)
            SCAN_BLANK: begin
               if (cnt == BLK_LAST) begin
                  state <= SCAN_ACTIVE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SCAN_ACTIVE: begin
               if (cnt == ACT_LAST) begin
                  state <= SLOT_START;
                  cnt   <= '0;
                  idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= SLOT_START;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver: 4 digits, 4 lit clocks and
// 1 blank clock per slot (20-clock frame). Two instances share all inputs:
// one active-high on both buses, one active-low on both buses.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_seven_segment_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] value;
   logic        load;
   logic        display_en;

   logic [6:0]  seg_a, seg_b;
   logic [3:0]  dig_a, dig_b;
   logic        frame_a, frame_b;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned k        = 0;
   logic [6:0]  pats [4];

   always #5 clk = ~clk;

   seven_segment_scan_driver #(
      .NUM_DIGITS     (4),
      .CLKS_PER_DIGIT (4),
      .BLANK_CLKS     (1),
      .SEG_ACTIVE_LOW (0),
      .DIG_ACTIVE_LOW (0)
   ) dut_hi (
      .clk_i        (clk),
      .rst_i        (rst),
      .value_i      (value),
      .load_i       (load),
      .display_en_i (display_en),
      .seg_o        (seg_a),
      .dig_en_o     (dig_a),
      .frame_o      (frame_a)
   );

   seven_segment_scan_driver #(
      .NUM_DIGITS     (4),
      .CLKS_PER_DIGIT (4),
      .BLANK_CLKS     (1),
      .SEG_ACTIVE_LOW (1),
      .DIG_ACTIVE_LOW (1)
   ) dut_lo (
      .clk_i        (clk),
      .rst_i        (rst),
      .value_i      (value),
      .load_i       (load),
      .display_en_i (display_en),
      .seg_o        (seg_b),
      .dig_en_o     (dig_b),
      .frame_o      (frame_b)
   );

   // Advance one clock; sampling happens on the falling edge.
   task automatic tick();
      @(negedge clk);
      k++;
   endtask

   task automatic chk(input string tag, input logic [6:0] es, input logic [3:0] ed, input logic ef);
      n_assert++;
      assert (seg_a === es) else begin
         n_fail++;
         $error("FAIL %s seg k=%0d: got %h expected %h", tag, k, seg_a, es);
      end
      n_assert++;
      assert (dig_a === ed) else begin
         n_fail++;
         $error("FAIL %s dig k=%0d: got %b expected %b", tag, k, dig_a, ed);
      end
      n_assert++;
      assert (frame_a === ef) else begin
         n_fail++;
         $error("FAIL %s frame k=%0d: got %b expected %b", tag, k, frame_a, ef);
      end
      n_assert++;
      assert (seg_b === ~es) else begin
         n_fail++;
         $error("FAIL %s seg_inv k=%0d: got %h expected %h", tag, k, seg_b, ~es);
      end
      n_assert++;
      assert (dig_b === ~ed) else begin
         n_fail++;
         $error("FAIL %s dig_inv k=%0d: got %b expected %b", tag, k, dig_b, ~ed);
      end
      n_assert++;
      assert (frame_b === ef) else begin
         n_fail++;
         $error("FAIL %s frame_inv k=%0d: got %b expected %b", tag, k, frame_b, ef);
      end
   endtask

   // k counts edges since reset release; outputs after edge k show scan position (k-1) mod 20.
   task automatic chk_scan(input string tag);
      int unsigned p;
      int unsigned d;
      logic        lit;
      logic [3:0]  ed;
      p   = (k - 1) % 20;
      d   = p / 5;
      lit = (p % 5) != 0;
      ed  = (lit && display_en) ? 4'(1 << d) : 4'h0;
      chk(tag, pats[d], ed, (k % 20) == 0);
   endtask

   task automatic set_pats(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3);
      pats[0] = p0;
      pats[1] = p1;
      pats[2] = p2;
      pats[3] = p3;
   endtask

   initial begin
      rst        = 1'b1;
      load       = 1'b0;
      value      = 16'h0000;
      display_en = 1'b1;
      tick();
      tick();
      chk("reset", 7'h00, 4'b0000, 1'b0);

      // Load 1234 in the first clock after reset release.
      rst   = 1'b0;
      load  = 1'b1;
      value = 16'h1234;
      k     = 0;
      set_pats(7'h7E, 7'h7E, 7'h7E, 7'h7E);
      tick();
      load = 1'b0;
      chk("first_blank", 7'h7E, 4'b0000, 1'b0);
      set_pats(7'h33, 7'h79, 7'h6D, 7'h30);
      repeat (20) begin
         tick();
         chk_scan("scan_1234");
      end
      repeat (60) begin
         tick();
         chk_scan("free_run");
      end

      display_en = 1'b0;
      repeat (20) begin
         tick();
         chk_scan("display_off");
      end
      display_en = 1'b1;
      repeat (11) begin
         tick();
         chk_scan("display_on");
      end

      // Position 12 is mid-lit of digit 2: reset there.
      rst = 1'b1;
      tick();
      chk("mid_reset", 7'h00, 4'b0000, 1'b0);
      rst = 1'b0;
      k   = 0;
`ifdef LEADING_ZERO_BLANK_EN
      set_pats(7'h7E, 7'h00, 7'h00, 7'h00);
`else
      set_pats(7'h7E, 7'h7E, 7'h7E, 7'h7E);
`endif
      repeat (21) begin
         tick();
         chk_scan("after_reset");
      end

      // Back-to-back loads while digit 0 is lit.
      load  = 1'b1;
      value = 16'hFFFF;
      tick();
      chk_scan("load_ffff_edge");
      value = 16'h000A;
      tick();
      load = 1'b0;
      chk("load_ffff", 7'h47, 4'b0001, 1'b0);
      tick();
      chk("load_000a", 7'h77, 4'b0001, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
      set_pats(7'h77, 7'h00, 7'h00, 7'h00);
`else
      set_pats(7'h77, 7'h7E, 7'h7E, 7'h7E);
`endif
      repeat (15) begin
         tick();
         chk_scan("scan_000a");
      end

      // Load at the last lit edge of digit 3 so the next frame shows the new value.
      load  = 1'b1;
      value = 16'h0050;
      tick();
      load = 1'b0;
      chk_scan("wrap_load_0050");
`ifdef LEADING_ZERO_BLANK_EN
      set_pats(7'h7E, 7'h5B, 7'h00, 7'h00);
`else
      set_pats(7'h7E, 7'h5B, 7'h7E, 7'h7E);
`endif
      repeat (19) begin
         tick();
         chk_scan("scan_0050");
      end
      load  = 1'b1;
      value = 16'h0000;
      tick();
      load = 1'b0;
      chk_scan("wrap_load_0000");
`ifdef LEADING_ZERO_BLANK_EN
      set_pats(7'h7E, 7'h00, 7'h00, 7'h00);
`else
      set_pats(7'h7E, 7'h7E, 7'h7E, 7'h7E);
`endif
      repeat (20) begin
         tick();
         chk_scan("scan_0000");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
